// File: rtl/spi_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// spi_arbiter_pkg
// Shared definitions for the SPI arbiter: controller state encoding, the
// layout of the per-requester configuration field and small width helpers.
//
// Configuration field (5 bits per requester):
//   [4:3] transaction length code (0 = 8, 1 = 16, 2 = 24, 3 = 32 bits)
//   [2]   CPOL
//   [1]   CPHA
//   [0]   default (idle) MOSI value
// -----------------------------------------------------------------------------
package spi_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } arb_state_t;

    localparam int SPI_DATA_W      = 32;
    localparam int CFG_W           = 5;
    localparam int CFG_DEFAULT_BIT = 0;
    localparam int CFG_CPHA_BIT    = 1;
    localparam int CFG_CPOL_BIT    = 2;
    localparam int CFG_LEN_LSB     = 3;
    localparam int CFG_LEN_W       = 2;

    // Index width that never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
// Combinational round-robin picker. The search starts at the requester after
// the previous winner and wraps around, so the previous winner has the lowest
// priority for the next pick.
//
// Ports:
//   i_req        - request vector, one bit per requester
//   i_last_grant - index of the previously granted requester
//   o_winner     - one-hot winner (all zero when no request)
//   o_index      - binary index of the winner
//   o_any        - at least one request is pending
// -----------------------------------------------------------------------------
module rr_select #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last_grant,
    output logic [N-1:0]  o_winner,
    output logic [IW-1:0] o_index,
    output logic          o_any
);

    // One extra bit so last_grant + offset never overflows before the wrap.
    logic [IW:0] w_cand;

    always_comb begin
        o_winner = '0;
        o_index  = '0;
        o_any    = 1'b0;
        w_cand   = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = {1'b0, i_last_grant} + (IW+1)'(k);
            if (w_cand >= (IW+1)'(N)) begin
                w_cand = w_cand - (IW+1)'(N);
            end
            if (!o_any && i_req[w_cand[IW-1:0]]) begin
                o_any                     = 1'b1;
                o_index                   = w_cand[IW-1:0];
                o_winner[w_cand[IW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// -----------------------------------------------------------------------------
// spi_arbiter
// Shares one spi_master between REQ_COUNT requesters. Requests are sampled
// only while idle; the winner's tx word, chip address and configuration are
// registered onto the spi_* outputs and held until the next grant. Each
// transaction ends with a done pulse (or a timeout pulse if the master never
// reports busy) followed by GAP_CYCLES idle cycles.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   req             - per-requester request
//   req_tx_data     - 32-bit tx word per requester (slice i = requester i)
//   req_addr        - chip address per requester
//   req_cfg         - {len[1:0], CPOL, CPHA, default} per requester
//   grant           - one-hot pulse when a request is latched
//   done            - one-hot pulse when a transaction completes
//   rx_data         - received word of the last completed transaction
//   busy            - high whenever the arbiter is not idle
//   timeout_err     - pulse when the master did not go busy in time
//   spi_*           - command interface of the shared spi_master
//   spi_busy        - master busy flag
//   spi_rx_data     - master received word
// -----------------------------------------------------------------------------
module spi_arbiter
    import spi_arbiter_pkg::*;
#(
    parameter int REQ_COUNT   = 4,
    parameter int SLAVE_COUNT = 8,
    parameter int GAP_CYCLES  = 2,
    parameter int TIMEOUT     = 8,
    localparam int ADDR_W     = idx_width(SLAVE_COUNT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REQ_COUNT-1:0]       req,
    input  logic [32*REQ_COUNT-1:0]    req_tx_data,
    input  logic [ADDR_W*REQ_COUNT-1:0] req_addr,
    input  logic [5*REQ_COUNT-1:0]     req_cfg,
    output logic [REQ_COUNT-1:0]       grant,
    output logic [REQ_COUNT-1:0]       done,
    output logic [31:0]                rx_data,
    output logic                       busy,
    output logic                       timeout_err,
    output logic                       spi_start,
    output logic [31:0]                spi_tx_data,
    output logic [ADDR_W-1:0]          spi_addr,
    output logic [1:0]                 spi_length,
    output logic                       spi_cpol,
    output logic                       spi_cpha,
    output logic                       spi_default,
    input  logic                       spi_busy,
    input  logic [31:0]                spi_rx_data
);

    localparam int IDX_W = idx_width(REQ_COUNT);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    // Per-requester views of the packed input buses.
    logic [SPI_DATA_W-1:0] w_tx_arr   [REQ_COUNT];
    logic [ADDR_W-1:0]     w_addr_arr [REQ_COUNT];
    logic [CFG_W-1:0]      w_cfg_arr  [REQ_COUNT];

    always_comb begin
        for (int i = 0; i < REQ_COUNT; i++) begin
            w_tx_arr[i]   = req_tx_data[i*SPI_DATA_W +: SPI_DATA_W];
            w_addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
            w_cfg_arr[i]  = req_cfg[i*CFG_W +: CFG_W];
        end
    end

    logic [REQ_COUNT-1:0] w_win_oh;
    logic [IDX_W-1:0]     w_win_idx;
    logic                 w_any;

    arb_state_t            r_state;
    logic [IDX_W-1:0]      r_last_grant;
    logic [REQ_COUNT-1:0]  r_winner_oh;
    logic [REQ_COUNT-1:0]  r_grant;
    logic [REQ_COUNT-1:0]  r_done;
    logic [SPI_DATA_W-1:0] r_rx_data;
    logic                  r_busy;
    logic                  r_timeout_err;
    logic                  r_start;
    logic [SPI_DATA_W-1:0] r_tx_data;
    logic [ADDR_W-1:0]     r_addr;
    logic [CFG_W-1:0]      r_cfg;
    logic [TMO_W-1:0]      r_tmo_cnt;
    logic [GAP_W-1:0]      r_gap_cnt;

    rr_select #(
        .N  (REQ_COUNT),
        .IW (IDX_W)
    ) u_rr_select (
        .i_req        (req),
        .i_last_grant (r_last_grant),
        .o_winner     (w_win_oh),
        .o_index      (w_win_idx),
        .o_any        (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= IDX_W'(REQ_COUNT - 1);
            r_winner_oh   <= '0;
            r_grant       <= '0;
            r_done        <= '0;
            r_rx_data     <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_start       <= 1'b0;
            r_tx_data     <= '0;
            r_addr        <= '0;
            r_cfg         <= '0;
            r_tmo_cnt     <= '0;
            r_gap_cnt     <= '0;
        end else begin
            // Pulse outputs default low; states below raise them for one cycle.
            r_grant       <= '0;
            r_done        <= '0;
            r_timeout_err <= 1'b0;
            r_start       <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_tx_data    <= w_tx_arr[w_win_idx];
                        r_addr       <= w_addr_arr[w_win_idx];
                        r_cfg        <= w_cfg_arr[w_win_idx];
                        r_winner_oh  <= w_win_oh;
                        r_last_grant <= w_win_idx;
                        r_grant      <= w_win_oh;
                        // spi_start is visible exactly while in LAUNCH.
                        r_start      <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_LAUNCH;
                    end
                end

                ST_LAUNCH: begin
                    r_tmo_cnt <= '0;
                    r_state   <= ST_WAIT_BUSY;
                end

                ST_WAIT_BUSY: begin
                    // The counter holds the number of WAIT_BUSY cycles already
                    // spent without busy; TIMEOUT such cycles end the attempt.
                    if (spi_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_gap_cnt     <= '0;
                        r_state       <= ST_GAP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end

                ST_WAIT_DONE: begin
                    if (!spi_busy) begin
                        r_rx_data <= spi_rx_data;
                        r_done    <= r_winner_oh;
                        r_gap_cnt <= '0;
                        r_state   <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign done        = r_done;
    assign rx_data     = r_rx_data;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;
    assign spi_start   = r_start;
    assign spi_tx_data = r_tx_data;
    assign spi_addr    = r_addr;
    assign spi_length  = r_cfg[CFG_LEN_LSB +: CFG_LEN_W];
    assign spi_cpol    = r_cfg[CFG_CPOL_BIT];
    assign spi_cpha    = r_cfg[CFG_CPHA_BIT];
    assign spi_default = r_cfg[CFG_DEFAULT_BIT];

endmodule

// File: tb/tb_spi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_arbiter
// Scoreboard bench for spi_arbiter with a loopback spi_master model.
// -----------------------------------------------------------------------------
module tb_spi_arbiter;

    localparam int RC   = 4;
    localparam int SC   = 8;
    localparam int GAPC = 2;
    localparam int TMO  = 8;
    localparam int AW   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [RC-1:0]     req;
    logic [32*RC-1:0]  req_tx_data;
    logic [AW*RC-1:0]  req_addr;
    logic [5*RC-1:0]   req_cfg;
    logic [RC-1:0]     grant;
    logic [RC-1:0]     done;
    logic [31:0]       rx_data;
    logic              busy;
    logic              timeout_err;
    logic              spi_start;
    logic [31:0]       spi_tx_data;
    logic [AW-1:0]     spi_addr;
    logic [1:0]        spi_length;
    logic              spi_cpol;
    logic              spi_cpha;
    logic              spi_default;
    logic              spi_busy;
    logic [31:0]       spi_rx_data;

    spi_arbiter #(
        .REQ_COUNT   (RC),
        .SLAVE_COUNT (SC),
        .GAP_CYCLES  (GAPC),
        .TIMEOUT     (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_tx_data (req_tx_data),
        .req_addr    (req_addr),
        .req_cfg     (req_cfg),
        .grant       (grant),
        .done        (done),
        .rx_data     (rx_data),
        .busy        (busy),
        .timeout_err (timeout_err),
        .spi_start   (spi_start),
        .spi_tx_data (spi_tx_data),
        .spi_addr    (spi_addr),
        .spi_length  (spi_length),
        .spi_cpol    (spi_cpol),
        .spi_cpha    (spi_cpha),
        .spi_default (spi_default),
        .spi_busy    (spi_busy),
        .spi_rx_data (spi_rx_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        logic [31:0] tx;
        logic [AW-1:0] addr;
        logic [4:0]  cfg;
        bit          tmo;
        bit          b2b;
    } exp_t;

    exp_t expq[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   model_last  = RC - 1;
    bit   m_dead      = 1'b0;
    int   m_hold      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] len_mask(input logic [1:0] l);
        case (l)
            2'd0:    return 32'h0000_00FF;
            2'd1:    return 32'h0000_FFFF;
            2'd2:    return 32'h00FF_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic set_req_data(input int i, input logic [31:0] tx,
                                input logic [AW-1:0] a, input logic [4:0] c);
        req_tx_data[i*32 +: 32] = tx;
        req_addr[i*AW +: AW]    = a;
        req_cfg[i*5 +: 5]       = c;
    endtask

    // Reference model: from the set of waiting requesters, each transaction
    // goes to the first one found after the previous winner, cyclically.
    task automatic plan(input logic [RC-1:0] mask, input int hold_n, input bit dead, output int n);
        logic [RC-1:0] pend;
        int c;
        exp_t e;
        pend = mask;
        n = (hold_n > 0) ? hold_n : $countones(mask);
        for (int t = 0; t < n; t++) begin
            c = -1;
            for (int k = 1; k <= RC; k++) begin
                if (c < 0 && pend[(model_last + k) % RC]) c = (model_last + k) % RC;
            end
            e.idx  = c;
            e.tx   = req_tx_data[c*32 +: 32];
            e.addr = req_addr[c*AW +: AW];
            e.cfg  = req_cfg[c*5 +: 5];
            e.tmo  = dead;
            e.b2b  = (t > 0);
            expq.push_back(e);
            model_last = c;
            if (hold_n == 0) pend[c] = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (busy !== 1'b0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (busy !== 1'b0) fail_now("idle_wait");
    endtask

    task automatic issue_batch(input logic [RC-1:0] mask, input int hold_n,
                               input bit dead, input bit scramble);
        int n;
        int w;
        plan(mask, hold_n, dead, n);
        m_dead = dead;
        req = mask;
        for (int t = 0; t < n; t++) begin
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (grant == '0 && w < 400);
            if (grant == '0) begin
                fail_now("grant_wait");
            end else begin
                if (hold_n == 0) req = req & ~grant;
                if (scramble) begin
                    for (int i = 0; i < RC; i++)
                        if (grant[i]) req_tx_data[i*32 +: 32] = ~req_tx_data[i*32 +: 32];
                end
            end
        end
        if (hold_n > 0) req = '0;
        @(negedge clk);
        wait_idle();
        m_dead = 1'b0;
    endtask

    // Loopback spi_master: MISO = MOSI, so the received word is the
    // transmitted word truncated to the transaction length.
    initial begin
        int m_st;
        int m_cnt;
        logic [31:0] m_word;
        m_st = 0;
        m_cnt = 0;
        m_word = '0;
        spi_busy = 1'b0;
        spi_rx_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_st = 0;
                spi_busy = 1'b0;
                spi_rx_data = '0;
            end else begin
                case (m_st)
                    0: if (spi_start && !m_dead) begin
                        m_word = spi_tx_data & len_mask(spi_length);
                        m_cnt  = $urandom_range(1, TMO - 1);
                        m_st   = 1;
                    end
                    1: begin
                        m_cnt--;
                        if (m_cnt == 0) begin
                            spi_busy = 1'b1;
                            m_cnt = (m_hold > 0) ? m_hold : $urandom_range(1, 5);
                            m_st = 2;
                        end
                    end
                    default: begin
                        m_cnt--;
                        if (m_cnt == 0) begin
                            spi_busy = 1'b0;
                            spi_rx_data = m_word;
                            m_st = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Monitor: pops the expected transaction on each grant and checks every
    // visible response of that transaction.
    initial begin
        exp_t cur;
        bit cur_valid;
        bit ended;
        int g_cyc;
        int e_cyc;
        int d;
        logic [31:0] last_rx;
        cur_valid = 1'b0;
        ended = 1'b0;
        g_cyc = 0;
        e_cyc = 0;
        last_rx = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cur_valid = 1'b0;
                last_rx = '0;
                continue;
            end
            if (grant != '0) begin
                if (expq.size() == 0) begin
                    fail_now("unexpected_grant");
                end else begin
                    cur = expq.pop_front();
                    chk("grant_onehot", grant, RC'(1) << cur.idx);
                    chk("start_with_grant", spi_start, 1);
                    chk("busy_at_grant", busy, 1);
                    chk("spi_cmd_at_grant",
                        {spi_tx_data, spi_addr, spi_length, spi_cpol, spi_cpha, spi_default},
                        {cur.tx, cur.addr, cur.cfg});
                    if (cur.b2b) chk("grant_spacing", cyc - e_cyc, GAPC + 1);
                    cur_valid = 1'b1;
                    ended = 1'b0;
                    g_cyc = cyc;
                end
            end else begin
                chk("start_single_cycle", spi_start, 0);
            end
            if (done != '0) begin
                if (!cur_valid || ended || cur.tmo) begin
                    fail_now("unexpected_done");
                end else begin
                    last_rx = cur.tx & len_mask(cur.cfg[4:3]);
                    chk("done_onehot", done, RC'(1) << cur.idx);
                    chk("rx_data", rx_data, last_rx);
                    ended = 1'b1;
                    e_cyc = cyc;
                end
            end
            if (timeout_err) begin
                if (!cur_valid || ended || !cur.tmo) begin
                    fail_now("unexpected_timeout");
                end else begin
                    d = cyc - g_cyc;
                    chk("timeout_latency_ok", (d >= TMO && d <= TMO + 1), 1);
                    chk("rx_hold_on_timeout", rx_data, last_rx);
                    ended = 1'b1;
                    e_cyc = cyc;
                end
            end
            if (cur_valid && grant == '0) begin
                if (busy) begin
                    chk("spi_cmd_stable",
                        {spi_tx_data, spi_addr, spi_length, spi_cpol, spi_cpha, spi_default},
                        {cur.tx, cur.addr, cur.cfg});
                end else begin
                    if (!ended) fail_now("txn_end_missing");
                    else chk("gap_length", cyc - e_cyc, GAPC);
                    cur_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        int n;
        int w;
        logic [RC-1:0] m;
        rst = 1'b1;
        req = '0;
        req_tx_data = '0;
        req_addr = '0;
        req_cfg = '0;
        repeat (3) @(negedge clk);
        chk("reset_pulses", {grant, done, busy, timeout_err, spi_start}, 0);
        chk("reset_rx_data", rx_data, 0);
        chk("reset_spi_cmd",
            {spi_tx_data, spi_addr, spi_length, spi_cpol, spi_cpha, spi_default}, 0);
        rst = 1'b0;
        @(negedge clk);

        // All four held after reset: 0,1,2,3,0.
        for (int i = 0; i < RC; i++) set_req_data(i, $urandom, AW'($urandom), 5'($urandom));
        issue_batch(4'b1111, 5, 1'b0, 1'b0);

        // Single 8-bit transfer of 0xA5 from requester 1.
        set_req_data(1, 32'h0000_00A5, 3'd3, 5'b00_0_0_0);
        issue_batch(4'b0010, 0, 1'b0, 1'b0);

        // Mode 3, 32-bit transfer from requester 2.
        set_req_data(2, 32'hDEAD_BEEF, 3'd5, 5'b11_1_1_0);
        issue_batch(4'b0100, 0, 1'b0, 1'b0);

        // Master never responds: two timeouts, then a normal transfer.
        set_req_data(0, $urandom, 3'd1, 5'b10_0_1_1);
        set_req_data(1, $urandom, 3'd2, 5'b01_1_0_0);
        issue_batch(4'b0011, 0, 1'b1, 1'b0);
        set_req_data(3, $urandom, 3'd7, 5'b11_0_0_1);
        issue_batch(4'b1000, 0, 1'b0, 1'b0);

        // Requester 3 changes its word right after being granted.
        set_req_data(3, 32'h1234_5678, 3'd4, 5'b11_0_1_0);
        issue_batch(4'b1000, 0, 1'b0, 1'b1);

        // Reset while the transfer is in progress.
        m_hold = 6;
        set_req_data(0, 32'hCAFE_F00D, 3'd6, 5'b11_0_0_0);
        plan(4'b0001, 0, 1'b0, n);
        req = 4'b0001;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (grant == '0 && w < 400);
        if (grant == '0) fail_now("abort_grant_wait");
        req = '0;
        w = 0;
        while (spi_busy !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (spi_busy !== 1'b1) fail_now("abort_busy_wait");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_pulses",
            {grant, done, busy, timeout_err, spi_start, spi_addr, spi_length,
             spi_cpol, spi_cpha, spi_default}, 0);
        chk("abort_rx_data", rx_data, 0);
        chk("abort_tx_data", spi_tx_data, 0);
        @(negedge clk);
        rst = 1'b0;
        m_hold = 0;
        model_last = RC - 1;
        @(negedge clk);
        set_req_data(0, 32'h0BAD_CAFE, 3'd2, 5'b01_0_0_1);
        issue_batch(4'b0001, 0, 1'b0, 1'b0);

        // Randomized batches.
        for (int b = 0; b < 30; b++) begin
            m = RC'($urandom_range(1, (1 << RC) - 1));
            for (int i = 0; i < RC; i++)
                if (m[i]) set_req_data(i, $urandom, AW'($urandom), 5'($urandom));
            issue_batch(m, 0, ($urandom_range(0, 7) == 0), 1'($urandom));
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
